field_cfg_dumper: RTL and testbench

Read-side counterpart of the field configuration loader. On a start pulse it scans the Game-of-Life field cell by cell in row-major order, presenting (x, y) read addresses to the field storage. It packs the returned cell bits LSB-first into bytes and streams them out over a valid/ready byte interface, for example toward a UART transmitter, so the host can read back the current field.

---
 rtl/field_pkg.sv | 21 ++
 rtl/field_scan_counter.sv | 50 +++++
 rtl/field_cfg_dumper.sv | 105 ++++++++++
 tb/tb_field_cfg_dumper.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/field_pkg.sv
// Shared definitions for the Game-of-Life field loader/dumper pair.
// Holds field size defaults, dumper FSM states and byte packing width.
package field_pkg;

  localparam int FIELD_W_DEF    = 5;
  localparam int FIELD_H_DEF    = 3;
  localparam int CELLS_PER_BYTE = 8;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    CAPT,
    SEND
  } dumper_state_t;

  // Address width that stays at least one bit for a 1-cell dimension.
  function automatic int adr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/field_scan_counter.sv
// Row-major x/y scan counter shared by field loader and dumper.
// Wraps back to (0,0) after the last cell.
module field_scan_counter
  import field_pkg::*;
#(
  parameter int  FIELD_W = FIELD_W_DEF,
  parameter int  FIELD_H = FIELD_H_DEF,
  localparam int XW      = adr_w(FIELD_W),
  localparam int YW      = adr_w(FIELD_H)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          clear,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          last
);

  localparam logic [XW-1:0] X_MAX = XW'(FIELD_W - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(FIELD_H - 1);

  logic x_end;
  logic y_end;

  assign x_end = (x == X_MAX);
  assign y_end = (y == Y_MAX);
  assign last  = x_end && y_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (clear) begin
      x <= '0;
      y <= '0;
    end else if (inc) begin
      if (last) begin
        x <= '0;
        y <= '0;
      end else if (x_end) begin
        x <= '0;
        y <= y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/field_cfg_dumper.sv
// Scans the field row-major, packs cells LSB-first into bytes
// and streams them out over a valid/ready byte interface.
module field_cfg_dumper
  import field_pkg::*;
#(
  parameter int  FIELD_W    = FIELD_W_DEF,
  parameter int  FIELD_H    = FIELD_H_DEF,
  localparam int X_ADR_SIZE = adr_w(FIELD_W),
  localparam int Y_ADR_SIZE = adr_w(FIELD_H)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_go,
  input  logic                  i_cell,
  input  logic                  i_ready,
  output logic                  o_is_dumping,
  output logic [X_ADR_SIZE-1:0] o_cur_x,
  output logic [Y_ADR_SIZE-1:0] o_cur_y,
  output logic [7:0]            o_data,
  output logic                  o_valid,
  output logic                  o_done
);

  localparam int CELLS = FIELD_W * FIELD_H;
  localparam int CNT_W = $clog2(CELLS + 1);

  dumper_state_t    state;
  logic [2:0]       bit_cnt;
  logic [CNT_W-1:0] cell_cnt;
  logic [7:0]       shreg;
  logic             last;
  logic             scan_clear;
  logic             scan_inc;
  logic             all_done;

  assign scan_clear = (state == IDLE) && i_go;
  assign scan_inc   = (state == CAPT);
  assign all_done   = (cell_cnt == CNT_W'(CELLS));
  assign o_data     = shreg;

  field_scan_counter #(
    .FIELD_W(FIELD_W),
    .FIELD_H(FIELD_H)
  ) u_scan (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (scan_inc),
    .clear(scan_clear),
    .x    (o_cur_x),
    .y    (o_cur_y),
    .last (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      cell_cnt     <= '0;
      shreg        <= '0;
      o_valid      <= 1'b0;
      o_done       <= 1'b0;
      o_is_dumping <= 1'b0;
    end else begin
      o_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_go) begin
            state        <= ADDR;
            bit_cnt      <= '0;
            cell_cnt     <= '0;
            shreg        <= '0;
            o_is_dumping <= 1'b1;
          end
        end
        ADDR: state <= CAPT;
        CAPT: begin
          shreg[bit_cnt] <= i_cell;
          bit_cnt        <= bit_cnt + 1'b1;
          cell_cnt       <= cell_cnt + 1'b1;
          if (bit_cnt == 3'(CELLS_PER_BYTE - 1) || last) begin
            state   <= SEND;
            o_valid <= 1'b1;
          end else begin
            state <= ADDR;
          end
        end
        SEND: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            shreg   <= '0;
            bit_cnt <= '0;
            if (all_done) begin
              state        <= IDLE;
              o_done       <= 1'b1;
              o_is_dumping <= 1'b0;
            end else begin
              state <= ADDR;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_field_cfg_dumper.sv
// Directed bench for field_cfg_dumper: 5x3 and 8x2 instances,
// vector table for whole dumps plus reset and back-to-back sequences.
module tb_field_cfg_dumper;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_go = 1'b0;
  logic i_ready = 1'b1;
  logic sel = 1'b0;

  logic       a_cell = 1'b0;
  logic       a_dump, a_valid, a_done;
  logic [2:0] a_x;
  logic [1:0] a_y;
  logic [7:0] a_data;

  logic       b_cell = 1'b0;
  logic       b_dump, b_valid, b_done;
  logic [2:0] b_x;
  logic [0:0] b_y;
  logic [7:0] b_data;

  always #5 clk = ~clk;

  field_cfg_dumper dut_a (
    .clk(clk), .rst_n(rst_n), .i_go(i_go), .i_cell(a_cell),
    .i_ready(i_ready), .o_is_dumping(a_dump), .o_cur_x(a_x),
    .o_cur_y(a_y), .o_data(a_data), .o_valid(a_valid), .o_done(a_done)
  );

  field_cfg_dumper #(.FIELD_W(8), .FIELD_H(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .i_go(i_go), .i_cell(b_cell),
    .i_ready(i_ready), .o_is_dumping(b_dump), .o_cur_x(b_x),
    .o_cur_y(b_y), .o_data(b_data), .o_valid(b_valid), .o_done(b_done)
  );

  // Field storage models: one-cycle registered read.
  always @(posedge clk) begin
    a_cell <= a_x[0] ^ a_y[0];
    b_cell <= 1'b1;
  end

  logic       m_dump, m_valid, m_done;
  logic [3:0] m_x, m_y;
  logic [7:0] m_data;

  assign m_dump  = sel ? b_dump : a_dump;
  assign m_valid = sel ? b_valid : a_valid;
  assign m_done  = sel ? b_done : a_done;
  assign m_data  = sel ? b_data : a_data;
  assign m_x     = sel ? {1'b0, b_x} : {1'b0, a_x};
  assign m_y     = sel ? {3'b0, b_y} : {2'b0, a_y};

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int k_start = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  coords[$];
  logic [7:0]  bytes[$];
  logic [7:0]  last_c, cur_c;
  logic        have_last;
  int          stab_err, done_cnt, done_cyc;
  logic        done_dump, prev_valid, prev_hs;
  logic [7:0]  done_xy;
  logic [15:0] prev_dc;

  always @(negedge clk) begin
    cur_c = {m_y, m_x};
    if (m_dump && !m_valid) begin
      if (!have_last || cur_c != last_c) coords.push_back(cur_c);
      last_c = cur_c;
      have_last = 1'b1;
    end
    if (m_valid && prev_valid && !prev_hs && ({m_data, cur_c} != prev_dc))
      stab_err++;
    if (m_valid && i_ready) bytes.push_back(m_data);
    if (m_done) begin
      done_cnt++;
      done_cyc = cyc;
      done_dump = m_dump;
      done_xy = cur_c;
    end
    prev_valid = m_valid;
    prev_hs = m_valid && i_ready;
    prev_dc = {m_data, cur_c};
  end

  task automatic clear_mon();
    coords.delete();
    bytes.delete();
    have_last = 1'b0;
    stab_err = 0;
    done_cnt = 0;
    done_cyc = 0;
    done_dump = 1'b0;
    done_xy = 8'h00;
    prev_valid = 1'b0;
    prev_hs = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_dump();
    tick();
    i_go = 1'b1;
    k_start = cyc + 1;
    tick();
    i_go = 1'b0;
  endtask

  task automatic run_dump(input int stall, input bit extra);
    clear_mon();
    i_ready = (stall == 0);
    start_dump();
    if (stall > 0) begin
      for (int i = 0; i < 100 && !m_valid; i++) tick();
      repeat (stall) tick();
      i_ready = 1'b1;
    end
    if (extra) begin
      repeat (5) tick();
      i_go = 1'b1;
      tick();
      i_go = 1'b0;
      repeat (9) tick();
      i_go = 1'b1;
      tick();
      i_go = 1'b0;
    end
    for (int i = 0; i < 200 && done_cnt == 0; i++) tick();
    if (done_cnt == 0) check("done_timeout", 0, 1);
    repeat (40) tick();
  endtask

  task automatic post_check(input string tag, input int lat, input int nb,
                            input logic [7:0] b0, input logic [7:0] b1);
    logic [31:0] got;
    int w, h, errs, idx;
    w = sel ? 8 : 5;
    h = sel ? 2 : 3;
    check({tag, "_nbytes"}, bytes.size(), nb);
    got = (bytes.size() > 0) ? {24'b0, bytes[0]} : 'x;
    check({tag, "_byte0"}, got, {24'b0, b0});
    got = (bytes.size() > 1) ? {24'b0, bytes[1]} : 'x;
    check({tag, "_byte1"}, got, {24'b0, b1});
    check({tag, "_done_lat"}, done_cyc - k_start, lat);
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_done_idle"}, {31'b0, done_dump}, 0);
    check({tag, "_done_xy"}, {24'b0, done_xy}, 0);
    check({tag, "_stable"}, stab_err, 0);
    check({tag, "_ncoords"}, coords.size(), w * h);
    errs = 0;
    idx = 0;
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++) begin
        if (idx >= coords.size() || coords[idx] != {y[3:0], x[3:0]})
          errs++;
        idx++;
      end
    check({tag, "_coords"}, errs, 0);
  endtask

  typedef struct {
    bit         sel;
    int         stall;
    bit         extra;
    int         lat;
    int         nb;
    logic [7:0] b0;
    logic [7:0] b1;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{1'b0, 0, 1'b0, 32, 2, 8'hAA, 8'h2A};
    vecs[1] = '{1'b0, 5, 1'b0, 37, 2, 8'hAA, 8'h2A};
    vecs[2] = '{1'b0, 0, 1'b1, 32, 2, 8'hAA, 8'h2A};
    vecs[3] = '{1'b1, 0, 1'b0, 34, 2, 8'hFF, 8'hFF};
    vecs[4] = '{1'b1, 3, 1'b0, 37, 2, 8'hFF, 8'hFF};

    clear_mon();
    repeat (3) tick();
    check("reset_a", {16'b0, a_dump, a_x, a_y, a_data, a_valid, a_done}, 0);
    check("reset_b", {17'b0, b_dump, b_x, b_y, b_data, b_valid, b_done}, 0);
    rst_n = 1'b1;
    repeat (2) tick();

    for (int v = 0; v < 5; v++) begin
      sel = vecs[v].sel;
      run_dump(vecs[v].stall, vecs[v].extra);
      post_check($sformatf("vec%0d", v), vecs[v].lat, vecs[v].nb,
                 vecs[v].b0, vecs[v].b1);
    end

    // Reset in the middle of a dump.
    sel = 1'b0;
    i_ready = 1'b1;
    clear_mon();
    start_dump();
    repeat (10) tick();
    check("mid_busy", {31'b0, a_dump}, 1);
    rst_n = 1'b0;
    #1;
    check("mid_reset_a", {16'b0, a_dump, a_x, a_y, a_data, a_valid, a_done}, 0);
    check("mid_reset_b", {17'b0, b_dump, b_x, b_y, b_data, b_valid, b_done}, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    clear_mon();
    repeat (20) tick();
    check("post_reset_bytes", bytes.size(), 0);
    check("post_reset_idle", {31'b0, a_dump}, 0);
    run_dump(0, 1'b0);
    post_check("after_reset", 32, 2, 8'hAA, 8'h2A);

    // Back-to-back dumps: go asserted in the done cycle.
    clear_mon();
    start_dump();
    for (int i = 0; i < 200 && !m_done; i++) tick();
    check("b2b_first_done", {31'b0, m_done}, 1);
    i_go = 1'b1;
    k_start = cyc + 1;
    tick();
    i_go = 1'b0;
    check("b2b_restart", {23'b0, m_dump, m_y, m_x}, 32'h100);
    for (int i = 0; i < 200 && done_cnt < 2; i++) tick();
    check("b2b_done_cnt", done_cnt, 2);
    check("b2b_lat", done_cyc - k_start, 32);
    check("b2b_nbytes", bytes.size(), 4);
    if (bytes.size() == 4)
      check("b2b_bytes", {bytes[0], bytes[1], bytes[2], bytes[3]},
            32'hAA2AAA2A);
    else
      check("b2b_bytes", 0, 32'hAA2AAA2A);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
